// File: rtl/key_scan_ctrl.sv
// Host-side keyboard scan controller: scan strobe, SKCTL/IRQEN/SKRES registers, key/break IRQs, KBCODE latch, overrun.
// Latency: register writes take effect one clk later; keyb_clk and irq_n are registered (one clk after the causing edge); rdata is combinational.
// Backpressure: none; every en tick and host write is accepted unconditionally.
module key_scan_ctrl #(
    parameter int SCAN_DIV = 114
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] addr,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       set_key,
    input  logic       set_break,
    input  logic       key_down,
    input  logic       k_shift,
    input  logic [7:0] kb_data,
    output logic       keyb_clk,
    output logic [1:0] skctls,
    output logic       irq_n
);

    localparam logic [3:0] ADDR_KBCODE = 4'h9;
    localparam logic [3:0] ADDR_SKRES  = 4'hA;
    localparam logic [3:0] ADDR_IRQ    = 4'hE;
    localparam logic [3:0] ADDR_SKCTL  = 4'hF;
    localparam logic [7:0] DIV_LAST    = 8'(SCAN_DIV - 1);

    logic [7:0] r_div;
    logic       r_keyb_clk;
    logic [1:0] r_skctls;
    logic [1:0] r_irqen;       // [1] = break enable (IRQEN bit 7), [0] = key enable (IRQEN bit 6)
    logic       r_pend_key;
    logic       r_pend_brk;
    logic       r_overrun;
    logic [7:0] r_kbcode;
    logic       r_irq_n;

    logic       w_wr_skres;
    logic       w_wr_irqen;
    logic       w_wr_skctl;
    logic       w_key_tick;
    logic       w_brk_tick;
    logic       w_pend_key_nxt;
    logic       w_pend_brk_nxt;

    // Decode host writes and core events; an IRQEN write of 0 beats a same-clk set.
    always_comb begin
        w_wr_skres = wr && (addr == ADDR_SKRES);
        w_wr_irqen = wr && (addr == ADDR_IRQ);
        w_wr_skctl = wr && (addr == ADDR_SKCTL);
        w_key_tick = en && set_key;
        w_brk_tick = en && set_break;

        w_pend_key_nxt = r_pend_key;
        if (w_key_tick && r_irqen[0]) begin
            w_pend_key_nxt = 1'b1;
        end
        if (w_wr_irqen && !wdata[6]) begin
            w_pend_key_nxt = 1'b0;
        end

        w_pend_brk_nxt = r_pend_brk;
        if (w_brk_tick && r_irqen[1]) begin
            w_pend_brk_nxt = 1'b1;
        end
        if (w_wr_irqen && !wdata[7]) begin
            w_pend_brk_nxt = 1'b0;
        end
    end

    // Scan divider and strobe: disabled scan parks the divider at 0 with keyb_clk high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= 8'd0;
            r_keyb_clk <= 1'b1;
        end else if (!r_skctls[1]) begin
            r_div      <= 8'd0;
            r_keyb_clk <= 1'b1;
        end else if (en) begin
            r_keyb_clk <= (r_div != DIV_LAST);
            r_div      <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
        end
    end

    // Host control registers; writes land regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skctls <= 2'b00;
            r_irqen  <= 2'b00;
        end else begin
            if (w_wr_skctl) begin
                r_skctls <= wdata[1:0];
            end
            if (w_wr_irqen) begin
                r_irqen <= wdata[7:6];
            end
        end
    end

    // Pending flags and the registered interrupt line, which follows the flags' new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_key <= 1'b0;
            r_pend_brk <= 1'b0;
            r_irq_n    <= 1'b1;
        end else begin
            r_pend_key <= w_pend_key_nxt;
            r_pend_brk <= w_pend_brk_nxt;
            r_irq_n    <= ~(w_pend_key_nxt | w_pend_brk_nxt);
        end
    end

    // Key code latch and overrun; a new key while one is still pending sets overrun, which beats SKRES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbcode  <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            if (w_key_tick) begin
                r_kbcode <= kb_data;
            end
            if (w_key_tick && r_pend_key) begin
                r_overrun <= 1'b1;
            end else if (w_wr_skres) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Read mux; status bits are active low and unused bits read as 1.
    always_comb begin
        rdata = 8'hFF;
        case (addr)
            ADDR_KBCODE: rdata = r_kbcode;
            ADDR_IRQ:    rdata = {~r_pend_brk, ~r_pend_key, 6'h3F};
            ADDR_SKCTL:  rdata = {2'b11, ~r_overrun, 1'b1, ~k_shift, ~key_down, 2'b11};
            default:     rdata = 8'hFF;
        endcase
    end

    assign keyb_clk = r_keyb_clk;
    assign skctls   = r_skctls;
    assign irq_n    = r_irq_n;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Randomized + directed bench for key_scan_ctrl (two instances: SCAN_DIV=4 and SCAN_DIV=8).
// Stimulus updates a register-level reference model and queues expected values.
// A negedge monitor pops the queue and compares against the DUT outputs.
module tb_key_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic       set_key;
    logic       set_break;
    logic       key_down;
    logic       k_shift;
    logic [7:0] kb_data;

    logic [7:0] rd4, rd8;
    logic       kclk4, kclk8;
    logic [1:0] skc4, skc8;
    logic       irq4, irq8;

    always #5 clk = ~clk;

    key_scan_ctrl #(.SCAN_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .wr(wr), .wdata(wdata), .rdata(rd4),
        .set_key(set_key), .set_break(set_break), .key_down(key_down), .k_shift(k_shift),
        .kb_data(kb_data), .keyb_clk(kclk4), .skctls(skc4), .irq_n(irq4)
    );

    key_scan_ctrl #(.SCAN_DIV(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .wr(wr), .wdata(wdata), .rdata(rd8),
        .set_key(set_key), .set_break(set_break), .key_down(key_down), .k_shift(k_shift),
        .kb_data(kb_data), .keyb_clk(kclk8), .skctls(skc8), .irq_n(irq8)
    );

    localparam int K_RD4 = 0, K_RD8 = 1, K_KCLK4 = 2, K_KCLK8 = 3;
    localparam int K_IRQ4 = 4, K_IRQ8 = 5, K_SKC4 = 6, K_SKC8 = 7;

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state (register level, not RTL structure).
    logic [1:0] m_irqen;
    logic [1:0] m_sk;
    logic       m_pk, m_pb, m_ov;
    logic [7:0] m_kb;
    int         m_n;       // en ticks since scan enable
    logic       m_k4, m_k8;

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: compare every queued expectation against the live DUT outputs.
    always @(negedge clk) begin
        item_t      it;
        logic [7:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_RD4:   act = rd4;
                K_RD8:   act = rd8;
                K_KCLK4: act = {7'd0, kclk4};
                K_KCLK8: act = {7'd0, kclk8};
                K_IRQ4:  act = {7'd0, irq4};
                K_IRQ8:  act = {7'd0, irq8};
                K_SKC4:  act = {6'd0, skc4};
                default: act = {6'd0, skc8};
            endcase
            chk(it.name, act, it.exp);
        end
    end

    task automatic push(int kind, logic [7:0] e, string nm);
        item_t t;
        t.kind = kind;
        t.exp  = e;
        t.name = nm;
        sb.push_back(t);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [7:0] rd_model(logic [3:0] a);
        case (a)
            4'h9:    return m_kb;
            4'hE:    return {~m_pb, ~m_pk, 6'h3F};
            4'hF:    return {2'b11, ~m_ov, 1'b1, ~k_shift, ~key_down, 2'b11};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_irqen = 2'b00; m_sk = 2'b00; m_pk = 0; m_pb = 0; m_ov = 0;
        m_kb = 8'h00; m_n = 0; m_k4 = 1; m_k8 = 1;
    endtask

    task automatic push_state();
        push(K_KCLK4, {7'd0, m_k4}, "keyb_clk4");
        push(K_KCLK8, {7'd0, m_k8}, "keyb_clk8");
        push(K_IRQ4, {7'd0, ~(m_pk | m_pb)}, "irq_n4");
        push(K_IRQ8, {7'd0, ~(m_pk | m_pb)}, "irq_n8");
        push(K_SKC4, {6'd0, m_sk}, "skctls4");
        push(K_SKC8, {6'd0, m_sk}, "skctls8");
    endtask

    task automatic rd_check(logic [3:0] a, string nm);
        addr = a;
        push(K_RD4, rd_model(a), nm);
        push(K_RD8, rd_model(a), nm);
        drain();
    endtask

    task automatic rd_const(logic [3:0] a, logic [7:0] e, string nm);
        addr = a;
        push(K_RD4, e, nm);
        push(K_RD8, e, nm);
        drain();
    endtask

    // One clock with the given inputs; model advances from pre-edge values.
    task automatic step(input logic e, input logic k, input logic b, input logic [7:0] kb,
                        input logic w, input logic [3:0] a, input logic [7:0] wd);
        logic npk, npb, nov;
        en = e; set_key = k; set_break = b; kb_data = kb; wr = w; addr = a; wdata = wd;
        npk = m_pk;
        if (e && k && m_irqen[0]) npk = 1'b1;
        if (w && a == 4'hE && !wd[6]) npk = 1'b0;
        npb = m_pb;
        if (e && b && m_irqen[1]) npb = 1'b1;
        if (w && a == 4'hE && !wd[7]) npb = 1'b0;
        nov = m_ov;
        if (w && a == 4'hA) nov = 1'b0;
        if (e && k && m_pk) nov = 1'b1;
        if (e && k) m_kb = kb;
        if (!m_sk[1]) begin
            m_n = 0; m_k4 = 1'b1; m_k8 = 1'b1;
        end else if (e) begin
            m_n++;
            m_k4 = (m_n % 4) != 0;
            m_k8 = (m_n % 8) != 0;
        end
        if (w && a == 4'hE) m_irqen = wd[7:6];
        if (w && a == 4'hF) m_sk = wd[1:0];
        m_pk = npk; m_pb = npb; m_ov = nov;
        @(posedge clk);
        #1;
        en = 0; set_key = 0; set_break = 0; wr = 0;
        push_state();
        drain();
    endtask

    task automatic wr_reg(logic [3:0] a, logic [7:0] d);
        step(0, 0, 0, 8'h00, 1, a, d);
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 0, 4'h0, 8'h00);
    endtask

    initial begin
        int lows4, lows8;
        rst = 1; en = 0; addr = 4'h0; wr = 0; wdata = 8'h00; set_key = 0; set_break = 0;
        key_down = 0; k_shift = 0; kb_data = 8'h00;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        push(K_KCLK4, 8'h01, "rst_keyb_clk");
        push(K_SKC4, 8'h00, "rst_skctls");
        push(K_IRQ4, 8'h01, "rst_irq_n");
        drain();
        rd_const(4'hE, 8'hFF, "rst_irqst");
        rd_const(4'hF, 8'hFF, "rst_skstat");
        rd_const(4'h9, 8'h00, "rst_kbcode");
        rst = 0;

        // Strobe period: 16 ticks -> 4 lows on SCAN_DIV=4, 2 on SCAN_DIV=8
        wr_reg(4'hF, 8'h03);
        lows4 = 0; lows8 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            lows4 += (kclk4 == 1'b0) ? 1 : 0;
            lows8 += (kclk8 == 1'b0) ? 1 : 0;
        end
        chk("strobe_count4", 8'(lows4), 8'd4);
        chk("strobe_count8", 8'(lows8), 8'd2);
        wr_reg(4'hF, 8'h00);

        // Key interrupt and overrun
        wr_reg(4'hE, 8'h40);
        step(1, 1, 0, 8'h3F, 0, 4'h0, 8'h00);
        push(K_IRQ4, 8'h00, "key_irq_n");
        drain();
        rd_const(4'hE, 8'hBF, "key_irqst");
        rd_const(4'h9, 8'h3F, "key_kbcode");
        step(1, 1, 0, 8'h12, 0, 4'h0, 8'h00);
        rd_const(4'hF, 8'hDF, "ovr_skstat");
        rd_const(4'h9, 8'h12, "ovr_kbcode");
        wr_reg(4'hA, 8'h5A);
        rd_const(4'hF, 8'hFF, "ovr_cleared");
        wr_reg(4'hE, 8'h00);
        push(K_IRQ4, 8'h01, "key_clr_irq_n");
        drain();
        rd_const(4'hE, 8'hFF, "key_clr_irqst");

        // Masked break, then clear-vs-set collision (write wins, code still latched)
        step(1, 0, 1, 8'h00, 0, 4'h0, 8'h00);
        push(K_IRQ4, 8'h01, "brk_masked_irq_n");
        drain();
        wr_reg(4'hE, 8'h40);
        step(1, 1, 0, 8'h55, 1, 4'hE, 8'h00);
        rd_const(4'hE, 8'hFF, "collide_irqst");
        rd_const(4'h9, 8'h55, "collide_kbcode");
        push(K_IRQ8, 8'h01, "collide_irq_n");
        drain();

        // Mid-period disable on SCAN_DIV=8
        wr_reg(4'hF, 8'h02);
        tick(5);
        wr_reg(4'hF, 8'h00);
        tick(3);
        wr_reg(4'hF, 8'h02);
        tick(7);
        push(K_KCLK8, 8'h01, "reen_before8");
        drain();
        tick(1);
        push(K_KCLK8, 8'h00, "reen_at8");
        drain();
        wr_reg(4'hF, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] a;
            logic       w;
            case ($urandom_range(0, 4))
                0: a = 4'hA;
                1: a = 4'hE;
                2: a = 4'hF;
                3: a = 4'h9;
                default: a = 4'($urandom_range(0, 15));
            endcase
            w = ($urandom_range(0, 3) == 0);
            key_down = 1'($urandom);
            k_shift  = 1'($urandom);
            step(1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), w, a, 8'($urandom));
            rd_check(4'($urandom_range(0, 15)), "rand_read");
        end

        // Async reset mid-operation
        key_down = 0; k_shift = 0;
        wr_reg(4'hE, 8'hC0);
        wr_reg(4'hF, 8'h03);
        step(1, 1, 1, 8'hA5, 0, 4'h0, 8'h00);
        for (int i = 0; i < 8 && m_k4; i++) tick(1);
        #2 rst = 1;
        #1;
        chk("arst_keyb_clk", {7'd0, kclk4}, 8'h01);
        chk("arst_irq_n", {7'd0, irq4}, 8'h01);
        chk("arst_skctls", {6'd0, skc4}, 8'h00);
        model_reset();
        @(negedge clk);
        #1 rst = 0;
        rd_check(4'h9, "arst_kbcode");
        rd_check(4'hE, "arst_irqst");
        tick(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
Host-side controller for the keyboard scan core. Generates the scan-step strobe (keyb_clk) and the two-bit scan control (skctls) that drive the core. Converts the core's set_key/set_break pulses into latched, maskable interrupts, holds KBCODE stable for the host, and tracks keyboard overrun. Sits between the CPU register decode and the keyboard core, and exposes the KBCODE, IRQST (bits 7:6), SKSTAT (bits 5, 3, 2), SKCTL, IRQEN and SKRES register slots.

Parameters:
SCAN_DIV, 114, number of en ticks per scan step; legal range 2..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  1.79 MHz tick; all state except rst and host writes advances only when en=1
addr  in  4  register address: 0x9 KBCODE(r), 0xA SKRES(w), 0xE IRQEN(w)/IRQST(r), 0xF SKCTL(w)/SKSTAT(r)
wr  in  1  single-clk write strobe, qualified by addr
wdata  in  8  write data
rdata  out  8  combinational read data selected by addr; 0xFF for unmapped addresses
set_key  in  1  core key-code-valid pulse, one en tick wide
set_break  in  1  core break pulse, one en tick wide
key_down  in  1  core key-currently-down status
k_shift  in  1  core shift status
kb_data  in  8  core code register {control, shift, code[5:0]}
keyb_clk  out  1  scan strobe to core; idle high
skctls  out  2  SKCTL bits 1:0 to core (bit0 = debounce enable, bit1 = scan enable)
irq_n  out  1  active-low interrupt request

Behaviour:
- Reset values:
  - keyb_clk = 1, skctls = 00, irq_n = 1.
  - irqen[7:6] = 00, pend_brk = 0, pend_key = 0, overrun = 0, kbcode = 0x00, divider = 0.
- Divider and strobe:
  - While skctls[1] = 1, the divider counts en ticks from 0 to SCAN_DIV-1 and then wraps to 0.
  - keyb_clk = 0 for exactly the en tick where divider = SCAN_DIV-1 (registered, so it changes one clk after that tick); otherwise keyb_clk = 1.
  - Strobe period is exactly SCAN_DIV en ticks.
- Scan disable:
  - While skctls[1] = 0, the divider is held at 0 and keyb_clk is held at 1.
  - Clearing skctls[1] mid-period aborts the period immediately.
  - After re-enable, the first strobe occurs SCAN_DIV en ticks later.
- SKCTL write (addr 0xF, wr = 1): skctls <= wdata[1:0] on that clk, independent of en. Other bits are ignored.
- IRQEN write (addr 0xE, wr = 1): irqen <= wdata[7:6]. Writing 0 to a bit clears the matching pending flag in the same clk.
- Interrupt set:
  - On an en tick with set_break = 1 and irqen[7] = 1: pend_brk <= 1.
  - On an en tick with set_key = 1 and irqen[6] = 1: pend_key <= 1.
  - Pending flags stay set until cleared by an IRQEN write of 0 to that bit or by rst.
- KBCODE capture:
  - On every en tick with set_key = 1: kbcode <= kb_data, regardless of irqen.
- Overrun:
  - On an en tick with set_key = 1 while pend_key is already 1: overrun <= 1. kbcode is still overwritten.
  - A write to SKRES (addr 0xA, any data) clears overrun.
- Simultaneous events:
  - IRQEN write clearing bit 6 in the same clk as a set_key tick: the flag ends cleared (write wins). kbcode is still captured.
  - SKRES write in the same clk as an overrun-causing set_key: overrun ends at 1 (set wins).
  - set_key and set_break on the same tick: both are processed independently.
- irq_n = ~(pend_key | pend_brk), registered.
- Read data:
  - KBCODE read: rdata = kbcode.
  - IRQST read (all bits active low): bit7 = ~pend_brk, bit6 = ~pend_key, bits 5:0 = 1.
  - SKSTAT read (active low): bit5 = ~overrun, bit3 = ~k_shift, bit2 = ~key_down; bits 7:6, 4, 1:0 = 1.
- rst asserted mid-operation: all state returns to its reset value asynchronously; keyb_clk goes high immediately.

Test Plan:
- Reset check: assert rst -> keyb_clk = 1, skctls = 00, irq_n = 1; reading 0xE gives 0xFF, 0xF gives 0xFF (with key_down = k_shift = 0), 0x9 gives 0x00.
- Strobe period: SCAN_DIV = 4, en every clk, write SKCTL = 0x03 -> keyb_clk low for 1 tick out of every 4; exactly 4 low pulses in 16 ticks.
- Key interrupt: IRQEN = 0x40, kb_data = 0x3F, pulse set_key -> irq_n = 0, IRQST = 0xBF, KBCODE = 0x3F; then write IRQEN = 0x00 -> irq_n = 1, IRQST = 0xFF.
- Overrun: with pend_key set, pulse set_key with kb_data = 0x12 -> SKSTAT bit5 = 0, KBCODE = 0x12; write SKRES -> SKSTAT bit5 = 1.
- Masked break plus collision: IRQEN = 0x00, pulse set_break -> irq_n stays 1. Then IRQEN = 0x40 with a same-clk write of 0x00 and a set_key tick -> pend_key = 0.
- Mid-period disable: SCAN_DIV = 8, disable scan at divider = 5, re-enable after 3 ticks -> next keyb_clk low occurs exactly 8 en ticks after re-enable.
